// File: rtl/bcd_seq_subtractor_if.sv
// rtl/bcd_seq_subtractor_if.sv - operand/result bundle for the sequential BCD subtractor
interface bcd_seq_subtractor_if #(
  parameter int DIGITS = 4
);
  logic                  start;
  logic [4*DIGITS-1:0]   a;
  logic [4*DIGITS-1:0]   b;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   diff;
  logic                  neg;
  logic                  err;

  modport master (
    output start, a, b,
    input  busy, done, diff, neg, err
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, neg, err
  );
endinterface

// File: rtl/bcd_seq_subtractor.sv
// rtl/bcd_seq_subtractor.sv - digit-serial sign-magnitude BCD subtractor |A-B|
module bcd_seq_subtractor #(
  parameter int DIGITS = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  bcd_seq_subtractor_if.slave    bus
);

  localparam int W  = 4 * DIGITS;
  localparam int IW = $clog2(DIGITS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SUB,
    S_FIX,
    S_DONE
  } state_t;

  state_t           state;
  logic [W-1:0]     a_reg;
  logic [W-1:0]     b_reg;
  logic [W-1:0]     r_reg;
  logic [IW-1:0]    idx;
  logic             borrow;

  logic             busy_q;
  logic             done_q;
  logic [W-1:0]     diff_q;
  logic             neg_q;
  logic             err_q;

  logic [3:0]       x_dig;
  logic [3:0]       y_dig;
  logic signed [4:0] t;
  logic [3:0]       res_dig;
  logic             borrow_nxt;
  logic [W-1:0]     r_upd;
  logic             last_dig;
  logic             in_bad;

  // One digit step: SUB uses a_i - b_i - borrow, FIX reuses the same path as 0 - r_i - borrow
  always_comb begin
    x_dig      = (state == S_FIX) ? 4'd0 : a_reg[{idx, 2'b00} +: 4];
    y_dig      = (state == S_FIX) ? r_reg[{idx, 2'b00} +: 4] : b_reg[{idx, 2'b00} +: 4];
    t          = $signed({1'b0, x_dig}) - $signed({1'b0, y_dig}) - $signed({4'b0000, borrow});
    borrow_nxt = t[4];
    // t is in -10..9, so adding 10 modulo 16 to the low nibble yields the 0..9 digit
    res_dig    = borrow_nxt ? (t[3:0] + 4'd10) : t[3:0];
    r_upd      = r_reg;
    r_upd[{idx, 2'b00} +: 4] = res_dig;
    last_dig   = (idx == IW'(DIGITS - 1));
  end

  // Flag any non-BCD digit on the incoming operands
  always_comb begin
    in_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bus.a[4*i +: 4] > 4'd9) in_bad = 1'b1;
      if (bus.b[4*i +: 4] > 4'd9) in_bad = 1'b1;
    end
  end

  // Control FSM with registered outputs; results are loaded only on entry to DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      a_reg  <= '0;
      b_reg  <= '0;
      r_reg  <= '0;
      idx    <= '0;
      borrow <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      diff_q <= '0;
      neg_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            a_reg  <= bus.a;
            b_reg  <= bus.b;
            r_reg  <= '0;
            idx    <= '0;
            borrow <= 1'b0;
            if (in_bad) begin
              state  <= S_DONE;
              done_q <= 1'b1;
              diff_q <= '0;
              neg_q  <= 1'b0;
              err_q  <= 1'b1;
            end else begin
              state  <= S_SUB;
              busy_q <= 1'b1;
            end
          end
        end

        S_SUB: begin
          r_reg <= r_upd;
          if (last_dig) begin
            idx    <= '0;
            borrow <= 1'b0;
            if (borrow_nxt) begin
              // Raw result is the 10's complement of a negative difference
              state <= S_FIX;
            end else begin
              state  <= S_DONE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
              diff_q <= r_upd;
              neg_q  <= 1'b0;
              err_q  <= 1'b0;
            end
          end else begin
            idx    <= idx + 1'b1;
            borrow <= borrow_nxt;
          end
        end

        S_FIX: begin
          r_reg <= r_upd;
          if (last_dig) begin
            idx    <= '0;
            borrow <= 1'b0;
            state  <= S_DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            diff_q <= r_upd;
            neg_q  <= 1'b1;
            err_q  <= 1'b0;
          end else begin
            idx    <= idx + 1'b1;
            borrow <= borrow_nxt;
          end
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.diff = diff_q;
  assign bus.neg  = neg_q;
  assign bus.err  = err_q;

endmodule
